// File: rtl/param_reg_arbiter_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the arbitrated register bank.
package param_reg_arb_pkg;

  localparam int unsigned DefaultN     = 4;
  localparam int unsigned DefaultW     = 32;
  localparam int unsigned DefaultDepth = 4;

  // Widest word the merge helper handles; callers cast to and from their own width.
  localparam int unsigned MaxW  = 256;
  localparam int unsigned MaxBe = MaxW / 8;

  typedef enum logic [0:0] {Arb, Locked} state_t;

  function automatic logic [MaxW-1:0] byte_merge(input logic [MaxW-1:0]  old_word,
                                                 input logic [MaxW-1:0]  new_word,
                                                 input logic [MaxBe-1:0] be);
    logic [MaxW-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < MaxBe; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/param_reg_arbiter_if.sv
// Write-side bus shared by the N requesters: packed per-requester request fields plus grant status.
interface param_reg_arbiter_if import param_reg_arb_pkg::*; #(
  parameter int unsigned N  = DefaultN,
  parameter int unsigned W  = DefaultW,
  parameter int unsigned AW = 2
);
  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_lock;
  logic [N*AW-1:0]    req_addr;
  logic [N*W-1:0]     req_data;
  logic [N*W/8-1:0]   req_be;
  logic [N-1:0]       req_ready;
  logic [IdW-1:0]     grant_id;

  modport master (
    output req_valid, req_lock, req_addr, req_data, req_be,
    input  req_ready, grant_id
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data, req_be,
    output req_ready, grant_id
  );

endinterface

// File: rtl/param_reg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester set at ptr+1, ptr+2, ... modulo N.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IdW'(j);
      end
    end
  end

endmodule

// File: rtl/param_reg_arbiter.sv
// Byte-enabled register bank written by N round-robin arbitrated requesters with optional
// grant lock; one registered read port with single-cycle latency and no write bypass.
module param_reg_arbiter import param_reg_arb_pkg::*; #(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned W     = DefaultW,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  param_reg_arbiter_if.slave   bus,
  input  logic [AW-1:0]        rd_addr,
  output logic [W-1:0]         rd_data
);

  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BeW = W / 8;

  state_t         state_q;
  logic [IdW-1:0] ptr_q, owner_q, grant_id_q;
  logic [W-1:0]   rd_data_q;
  logic [W-1:0]   bank_q [DEPTH];

  logic [N-1:0]   arb_gnt;
  logic [IdW-1:0] arb_idx;
  logic [N-1:0]   ready;
  logic [IdW-1:0] sel;
  logic           xfer, sel_lock, wr_en;
  logic [AW-1:0]  wr_addr;
  logic [W-1:0]   wr_data;
  logic [BeW-1:0] wr_be;

  rr_arbiter #(
    .N   (N),
    .IdW (IdW)
  ) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // While locked, only the owner sees ready; the arbiter result is ignored.
  always_comb begin
    ready = '0;
    sel   = arb_idx;
    if (state_q == Arb) begin
      ready = arb_gnt;
    end else begin
      sel          = owner_q;
      ready[sel]   = bus.req_valid[sel];
    end
    xfer     = |ready;
    sel_lock = bus.req_lock[sel];
    wr_addr  = bus.req_addr[sel*AW +: AW];
    wr_data  = bus.req_data[sel*W +: W];
    wr_be    = bus.req_be[sel*BeW +: BeW];
    // Out-of-range addresses are still accepted, they just write nothing.
    wr_en    = xfer && (32'(wr_addr) < DEPTH);
  end

  assign bus.req_ready = ready;
  assign bus.grant_id  = grant_id_q;
  assign rd_data       = rd_data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= Arb;
      ptr_q      <= IdW'(N - 1);
      owner_q    <= '0;
      grant_id_q <= '0;
    end else begin
      unique case (state_q)
        Arb: begin
          if (xfer) begin
            ptr_q      <= sel;
            grant_id_q <= sel;
            if (sel_lock) begin
              state_q <= Locked;
              owner_q <= sel;
            end
          end
        end
        Locked: begin
          // No transfer here means the owner dropped valid, which releases the lock.
          if (xfer) begin
            ptr_q      <= sel;
            grant_id_q <= sel;
            if (!sel_lock) state_q <= Arb;
          end else begin
            state_q <= Arb;
          end
        end
        default: state_q <= Arb;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        bank_q[wr_addr] <= W'(byte_merge(MaxW'(bank_q[wr_addr]), MaxW'(wr_data),
                                         MaxBe'(wr_be)));
      end
      rd_data_q <= (32'(rd_addr) < DEPTH) ? bank_q[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_param_reg_arbiter.sv
// Directed bench for param_reg_arbiter: arbitration order, byte enables, locking, read latency, reset.
module tb_param_reg_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          resetn;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  int vectors     = 0;
  int miscompares = 0;

  param_reg_arbiter_if #(.N(N), .W(W), .AW(AW)) bus ();

  param_reg_arbiter #(
    .N     (N),
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_be    = '0;
  endtask

  task automatic set_req(input int i, input logic lock, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input logic [W/8-1:0] be);
    bus.req_valid[i]             = 1'b1;
    bus.req_lock[i]              = lock;
    bus.req_addr[i*AW +: AW]     = a;
    bus.req_data[i*W +: W]       = d;
    bus.req_be[i*W/8 +: W/8]     = be;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d2  [4] = '{32'h10101010, 32'h21212121, 32'hA5A5A5A5, 32'h43434343};
  int          ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    resetn  = 1'b0;
    rd_addr = '0;
    clear_reqs();
    tick();
    tick();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_grant_id", 32'(bus.grant_id), 32'h0);
    resetn = 1'b1;
    #1;
    check("idle_ready", 32'(bus.req_ready), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = AW'(a);
      tick();
      check("rst_bank_read", rd_data, 32'h0);
    end

    // All four valid, no lock: 0,1,2,3,0; same-edge read of addr 2 returns old value.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(i), d2[i], 4'hF);
    rd_addr = 2'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(1) << ord[k]);
      tick();
      check("rr_grant_id", 32'(bus.grant_id), 32'(ord[k]));
      if (k == 2) check("rd_same_edge_old", rd_data, 32'h0);
      if (k == 3) check("rd_next_cycle_new", rd_data, 32'hA5A5A5A5);
    end
    clear_reqs();

    // Byte enables, then a be=0 transfer that must not touch the word.
    set_req(1, 1'b0, 2'd1, 32'h11223344, 4'hF);
    #1;
    check("be_ready_full", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 2'd1, 32'hFFFFFFFF, 4'b0101);
    #1;
    check("be_ready_part", 32'(bus.req_ready), 32'h2);
    tick();
    check("be_grant_id", 32'(bus.grant_id), 32'h1);
    clear_reqs();
    set_req(0, 1'b0, 2'd1, 32'h00000000, 4'h0);
    #1;
    check("be0_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("be0_grant_id", 32'(bus.grant_id), 32'h0);
    clear_reqs();
    rd_addr = 2'd1;
    tick();
    check("be_merge_read", rd_data, 32'h11FF33FF);

    // Lock: requester 2 locks, then holds the grant while 0 and 1 compete.
    set_req(2, 1'b1, 2'd3, 32'hC0DE0001, 4'hF);
    #1;
    check("lock_enter_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check("lock_enter_grant", 32'(bus.grant_id), 32'h2);
    set_req(0, 1'b0, 2'd0, 32'h0F0F0F0F, 4'hF);
    set_req(1, 1'b0, 2'd1, 32'h00000000, 4'h0);
    for (int t = 0; t < 3; t++) begin
      set_req(2, (t < 2), 2'd3, 32'hC0DE0002 + 32'(t), 4'hF);
      #1;
      check("lock_hold_ready", 32'(bus.req_ready), 32'h4);
      tick();
      check("lock_hold_grant", 32'(bus.grant_id), 32'h2);
    end
    bus.req_valid[2] = 1'b0;
    #1;
    check("post_lock_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("post_lock_grant", 32'(bus.grant_id), 32'h0);
    clear_reqs();

    // Owner going idle while locked releases the lock on the next cycle.
    set_req(2, 1'b1, 2'd2, 32'h5A5A5A5A, 4'hF);
    #1;
    check("idle_lock_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid[2] = 1'b0;
    set_req(0, 1'b0, 2'd0, 32'h77777777, 4'hF);
    #1;
    check("locked_idle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check("locked_idle_grant", 32'(bus.grant_id), 32'h2);
    #1;
    check("release_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("release_grant", 32'(bus.grant_id), 32'h0);
    clear_reqs();

    // Same-address write/read, then reset while requester 3 holds the lock.
    rd_addr = 2'd3;
    set_req(3, 1'b1, 2'd3, 32'hDEADBEEF, 4'hF);
    set_req(0, 1'b0, 2'd0, 32'h12121212, 4'hF);
    #1;
    check("wr_rd_ready", 32'(bus.req_ready), 32'h8);
    tick();
    check("wr_rd_old", rd_data, 32'hC0DE0004);
    check("wr_rd_grant", 32'(bus.grant_id), 32'h3);
    set_req(3, 1'b1, 2'd3, 32'h01234567, 4'hF);
    #1;
    check("owner_only_ready", 32'(bus.req_ready), 32'h8);
    tick();
    check("wr_rd_new", rd_data, 32'hDEADBEEF);
    resetn = 1'b0;
    #1;
    check("async_rst_rd_data", rd_data, 32'h0);
    check("async_rst_grant", 32'(bus.grant_id), 32'h0);
    clear_reqs();
    tick();
    resetn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_addr = AW'(a);
      tick();
      check("post_rst_bank_read", rd_data, 32'h0);
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(i), 32'h0, 4'hF);
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("post_rst_grant", 32'(bus.grant_id), 32'h0);
    clear_reqs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
